fft8_frame_ctrl: RTL
====================

// Module: fft8_frame_ctrl
// PURPOSE
//  Frame sequencer for the 3-stage 8-point FFT datapath (stage1..stage3, each 1 registered cycle).
//  Accepts 8 real samples serially, presents them bit-reversed as a parallel frame, waits the pipe latency,
//  captures the 8 complex bins, and streams them out in natural order with valid/ready handshake.
//  Sits between the sample source and the downstream consumer; one frame in flight at a time.
// PARAMETERS
//  DW        16  sample/bin word width (two's complement)
//  PIPE_LAT  3   clock cycles from x_bus stable to X_bus valid (one per stage)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous reset, active-high
//  in_valid   in   1       source has sample on in_data
//  in_ready   out  1       controller can accept a sample
//  in_data    in   DW      real input sample x[n], n = arrival order 0..7
//  x_bus      out  8*DW    to datapath; slot s = bits[DW*s +: DW] holds x[bitrev3(s)]
//  X_re_bus   in   8*DW    datapath real outputs, slot k = bin k
//  X_im_bus   in   8*DW    datapath imag outputs, slot k = bin k (bins 0,4 driven 0 by datapath)
//  out_valid  out  1       out_re/out_im/out_idx hold a bin
//  out_ready  in   1       consumer accepts bin
//  out_re     out  DW      real part of bin out_idx
//  out_im     out  DW      imag part of bin out_idx
//  out_idx    out  3       bin index k, 0..7
//  out_last   out  1       high with bin 7
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, cnt=0, x_bus=0, out buffer=0, in_ready=1, out_valid=0, out_re=out_im=0,
//   out_idx=0, out_last=0, busy=0. Reset mid-frame discards the frame; no partial output after release.
//  States: IDLE -> LOAD -> RUN -> UNLOAD -> IDLE.
//  IDLE: in_ready=1. Accept (in_valid&in_ready) writes x[0] into slot bitrev3(0)=0, cnt=1, go LOAD.
//  LOAD: in_ready=1. Each accept writes in_data to slot bitrev3(cnt), cnt++. Accept with cnt==7 -> RUN, cnt=0.
//   No accept -> hold; in_valid gaps any length. Slots not yet written keep previous frame values.
//  RUN: in_ready=0, x_bus held constant. cnt counts cycles; at cnt==PIPE_LAT-1 latch X_re_bus/X_im_bus into
//   out buffer, cnt=0, go UNLOAD. Datapath latency: last sample accepted at edge E -> capture at edge E+PIPE_LAT.
//  UNLOAD: in_ready=0. out_valid=1, out_idx=cnt, out_re/out_im=buffer[cnt], out_last=(cnt==7).
//   Transfer = out_valid&out_ready; on transfer cnt++; transfer with cnt==7 -> IDLE, out_valid=0 next cycle.
//   out_ready low: all out_* held stable (AXI-style: valid never drops without transfer).
//  Next frame may start only from IDLE (no overlap); first sample accepted the cycle after out_last transfer.
//  Arithmetic: none in controller; words passed bit-exact. Scaling/overflow owned by datapath.
//  bitrev3: slot order 0,4,2,6,1,5,3,7 for n=0..7.
//  in_data/in_valid during RUN/UNLOAD ignored (in_ready=0); X_*_bus ignored outside RUN capture edge.
//  Minimum frame period: 8 (load) + PIPE_LAT + 8 (unload) cycles with in_valid/out_ready held high.
// TESTING
//  Impulse x=[0x0100,0,...,0] -> bins k=0..7 each re=0x0100 im=0, idx 0..7, out_last only at idx 7.
//  DC x=all 0x0010 -> bin0 re=0x0080 im=0, bins1..7 re=im=0; x_bus slots all 0x0010.
//  Load order x=n+1 (1..8) -> x_bus slots = 1,5,3,7,2,6,4,8; capture exactly PIPE_LAT=3 edges after 8th accept.
//  out_ready toggled 1,0,0,1 per cycle -> outputs stable while low, 8 transfers, no bin skipped/duplicated.
//  in_valid held high throughout -> in_ready low in RUN/UNLOAD; frame 2 starts cycle after out_last; 19-cycle period.
//  rst pulse after 3rd UNLOAD transfer -> all outputs 0 immediately; next frame of 8 samples yields correct bins.

Source files
------------

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 3-stage 8-point FFT datapath: serial sample load in bit-reversed slot order,
// a fixed wait for the pipe latency, bin capture, then natural-order bin streaming with valid/ready.
module fft8_frame_ctrl #(
   parameter int DW       = 16,
   parameter int PIPE_LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic [8*DW-1:0] x_bus,
   input  logic [8*DW-1:0] X_re_bus,
   input  logic [8*DW-1:0] X_im_bus,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_re,
   output logic [DW-1:0]   out_im,
   output logic [2:0]      out_idx,
   output logic            out_last,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

   localparam logic [2:0] RUN_LAST = 3'(PIPE_LAT - 1);

   state_t            state;
   logic [2:0]        cnt;
   logic [8*DW-1:0]   re_buf;
   logic [8*DW-1:0]   im_buf;

   logic              accept;
   logic              xfer;
   logic [2:0]        cnt_inc;

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

   assign accept  = in_valid & in_ready;
   assign xfer    = out_valid & out_ready;
   assign cnt_inc = cnt + 3'd1;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         x_bus     <= '0;
         // NOTE: the bin buffer is cleared on reset so no stale frame can ever be observed.
         re_buf    <= '0;
         im_buf    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  x_bus[int'(bitrev3(cnt))*DW +: DW] <= in_data;
                  busy <= 1'b1;
                  if (cnt == 3'd7) begin
                     state    <= RUN;
                     cnt      <= '0;
                     in_ready <= 1'b0;
                  end else begin
                     state <= LOAD;
                     cnt   <= cnt_inc;
                  end
               end
            end

            RUN: begin
               // x_bus is frozen here; the datapath result is valid once the pipe has filled.
               if (cnt == RUN_LAST) begin
                  re_buf    <= X_re_bus;
                  im_buf    <= X_im_bus;
                  out_re    <= X_re_bus[DW-1:0];
                  out_im    <= X_im_bus[DW-1:0];
                  out_idx   <= '0;
                  out_last  <= 1'b0;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= UNLOAD;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            UNLOAD: begin
               if (xfer) begin
                  if (cnt == 3'd7) begin
                     state     <= IDLE;
                     cnt       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     cnt      <= cnt_inc;
                     out_idx  <= cnt_inc;
                     out_re   <= re_buf[int'(cnt_inc)*DW +: DW];
                     out_im   <= im_buf[int'(cnt_inc)*DW +: DW];
                     out_last <= (cnt_inc == 3'd7);
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
